// File: rtl/fir_pkg.sv
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and width helpers for the polyphase FIR interpolator.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fir_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Derived widths: NB_PROD, NB_ACC and NBF_ACC of a given configuration
    function automatic int calc_nb_prod(input int nb_in, input int nb_coeff);
        return nb_in + nb_coeff;
    endfunction

    function automatic int calc_nb_acc(input int nb_in, input int nb_coeff, input int n_branch);
        return nb_in + nb_coeff + clog2(n_branch);
    endfunction

    function automatic int calc_nbf_acc(input int nbf_in, input int nbf_coeff);
        return nbf_in + nbf_coeff;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sat_round.sv
// ============================================================================
//  Module      : fir_sat_round
//  Description : Aligns the accumulator to the output format and saturates.
//                FIR_POLY_ROUND_EN selects round-half-up on dropped LSBs.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fir_sat_round #(
    parameter int NB_ACC  = 19,
    parameter int NBF_ACC = 14,
    parameter int NB_OUT  = 18,
    parameter int NBF_OUT = 17
) (
    input  logic signed [NB_ACC-1:0] i_acc,
    output logic signed [NB_OUT-1:0] o_sample,
    output logic                     o_sat
);

    localparam int c_sh   = (NBF_OUT >= NBF_ACC) ? NBF_OUT - NBF_ACC : 0;
    localparam int c_drop = (NBF_OUT >= NBF_ACC) ? 0 : NBF_ACC - NBF_OUT;
    // Wide enough that neither the left shift nor the rounding add can wrap
    localparam int c_wx   = NB_ACC + NB_OUT + c_sh + 2;

    localparam logic signed [c_wx-1:0] c_max = {{(c_wx-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
    localparam logic signed [c_wx-1:0] c_min = ~c_max;

    logic signed [c_wx-1:0] w_ext;
    logic signed [c_wx-1:0] w_aligned;

    assign w_ext = {{(c_wx-NB_ACC){i_acc[NB_ACC-1]}}, i_acc};

    generate
        if (c_drop == 0) begin : g_shift_left
            assign w_aligned = w_ext <<< c_sh;
        end else begin : g_drop
`ifdef FIR_POLY_ROUND_EN
            localparam logic signed [c_wx-1:0] c_half = c_wx'(1) <<< (c_drop - 1);
            assign w_aligned = (w_ext + c_half) >>> c_drop;
`else
            assign w_aligned = w_ext >>> c_drop;
`endif
        end
    endgenerate

    always_comb begin
        o_sat    = 1'b0;
        o_sample = w_aligned[NB_OUT-1:0];
        if (w_aligned > c_max) begin
            o_sample = c_max[NB_OUT-1:0];
            o_sat    = 1'b1;
        end else if (w_aligned < c_min) begin
            o_sample = c_min[NB_OUT-1:0];
            o_sat    = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_poly_interp.sv
// ============================================================================
//  Module      : fir_poly_interp
//  Description : Polyphase FIR interpolator (OS outputs per input sample) with
//                writable coefficients; optional rounding via FIR_POLY_ROUND_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fir_poly_interp
    import fir_pkg::*;
#(
    parameter int N_TAPS    = 24,
    parameter int OS        = 4,
    parameter int NB_COEFF  = 8,
    parameter int NBF_COEFF = 7,
    parameter int NB_IN     = 8,
    parameter int NBF_IN    = 7,
    parameter int NB_OUT    = 18,
    parameter int NBF_OUT   = 17
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic signed [NB_IN-1:0]      i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_coeff_we,
    input  logic [clog2(N_TAPS)-1:0]     i_coeff_addr,
    input  logic signed [NB_COEFF-1:0]   i_coeff_data,
    output logic signed [NB_OUT-1:0]     o_sample,
    output logic                         o_valid,
    output logic                         o_sat
);

    localparam int c_l       = N_TAPS / OS;
    localparam int c_nb_addr = clog2(N_TAPS);
    localparam int c_nb_p    = clog2(OS);
    localparam int c_nb_prod = calc_nb_prod(NB_IN, NB_COEFF);
    localparam int c_nb_acc  = calc_nb_acc(NB_IN, NB_COEFF, c_l);
    localparam int c_nbf_acc = calc_nbf_acc(NBF_IN, NBF_COEFF);

    state_t                     r_state, w_state_next;
    logic [c_nb_p-1:0]          r_phase, w_phase_next;
    logic                       w_last, w_accept, w_run;

    logic signed [NB_IN-1:0]    r_x     [c_l];
    logic signed [NB_COEFF-1:0] r_coeff [N_TAPS];
    logic signed [NB_COEFF-1:0] w_coef  [c_l];
    logic [c_nb_addr-1:0]       w_cidx  [c_l];
    logic signed [c_nb_prod-1:0] w_prod [c_l];
    logic signed [c_nb_prod-1:0] r_prod [c_l];
    logic                       r_v1;

    logic signed [c_nb_acc-1:0] w_acc;
    logic signed [NB_OUT-1:0]   w_sample, r_sample;
    logic                       w_sat, r_sat, r_valid;

    assign w_last   = (r_phase == c_nb_p'(OS - 1));
    assign w_run    = (r_state == ST_RUN);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        o_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_next = ST_RUN;
                    w_phase_next = '0;
                end
            end
            ST_RUN: begin
                o_ready = w_last;
                if (w_last) begin
                    // A sample offered on the last phase keeps the output stream gapless
                    w_phase_next = '0;
                    if (!i_valid) w_state_next = ST_IDLE;
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            for (int k = 0; k < c_l; k++) r_x[k] <= '0;
        end else if (w_accept) begin
            for (int k = c_l - 1; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            for (int i = 0; i < N_TAPS; i++) r_coeff[i] <= '0;
        end else if (i_coeff_we && (int'(i_coeff_addr) < N_TAPS)) begin
            r_coeff[i_coeff_addr] <= i_coeff_data;
        end
    end

    generate
        for (genvar k = 0; k < c_l; k++) begin : g_tap
            assign w_cidx[k] = c_nb_addr'(k * OS) + c_nb_addr'(r_phase);
            assign w_coef[k] = r_coeff[w_cidx[k]];
            assign w_prod[k] = c_nb_prod'(r_x[k]) * c_nb_prod'(w_coef[k]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < c_l; k++) r_prod[k] <= '0;
        end else begin
            r_v1 <= w_run;
            for (int k = 0; k < c_l; k++) r_prod[k] <= w_prod[k];
        end
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < c_l; k++) w_acc = w_acc + c_nb_acc'(r_prod[k]);
    end

    fir_sat_round #(
        .NB_ACC  (c_nb_acc),
        .NBF_ACC (c_nbf_acc),
        .NB_OUT  (NB_OUT),
        .NBF_OUT (NBF_OUT)
    ) u_sat_round (
        .i_acc    (w_acc),
        .o_sample (w_sample),
        .o_sat    (w_sat)
    );

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_valid  <= 1'b0;
            r_sat    <= 1'b0;
            r_sample <= '0;
        end else begin
            r_valid <= r_v1;
            r_sat   <= r_v1 && w_sat;
            if (r_v1) r_sample <= w_sample;
        end
    end

    assign o_valid  = r_valid;
    assign o_sat    = r_sat;
    assign o_sample = r_sample;

endmodule

`default_nettype wire

// File: tb/tb_fir_poly_interp.sv
// ============================================================================
//  Module      : tb_fir_poly_interp
//  Description : Self-checking bench for fir_poly_interp (default and a narrow
//                NB_OUT=10/NBF_OUT=7 instance sharing the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_poly_interp;

    localparam int c_n   = 24;
    localparam int c_os  = 4;
    localparam int c_l   = c_n / c_os;
    localparam int c_nbf = 14;

    logic              clk;
    logic              i_reset;
    logic signed [7:0] i_data;
    logic              i_valid;
    logic              i_coeff_we;
    logic [4:0]        i_coeff_addr;
    logic signed [7:0] i_coeff_data;
    logic              o_ready, o_valid, o_sat;
    logic signed [17:0] o_sample;
    logic              o_ready2, o_valid2, o_sat2;
    logic signed [9:0] o_sample2;

    fir_poly_interp dut (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
        .o_sample(o_sample), .o_valid(o_valid), .o_sat(o_sat)
    );

    fir_poly_interp #(.NB_OUT(10), .NBF_OUT(7)) dut2 (
        .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready2),
        .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
        .o_sample(o_sample2), .o_valid(o_valid2), .o_sat(o_sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; longint acc; } exp_t;

    int     checks, errors;
    int     m_coeff [c_n];
    int     m_x     [c_l];
    int     ec, last_acc;
    bit     m_accepted;
    longint last1, last2;
    exp_t   q [$];
    int     obs_s [$];
    int     obs_sat [$];
    int     obs2_s [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
        end
    endtask

    // Exact real-valued sum rescaled to the output format, then clamped
    function automatic longint scale(input longint acc, input int nbo, input int nbfo, output bit sat);
        longint den, v, hi, lo;
        int d;
        d = c_nbf - nbfo;
        if (d <= 0) begin
            v = acc * (longint'(1) << (-d));
        end else begin
            den = longint'(1) << d;
`ifdef FIR_POLY_ROUND_EN
            acc = acc + den / 2;
`endif
            v = acc / den;
            if ((acc % den != 0) && (acc < 0)) v = v - 1;
        end
        hi  = (longint'(1) << (nbo - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
        if (v > hi) begin v = hi; sat = 1'b1; end
        else if (v < lo) begin v = lo; sat = 1'b1; end
        return v;
    endfunction

    // One clock: predict this cycle, apply edge effects to the model, check after the edge
    task automatic tick();
        int     ph;
        longint acc, e1, e2;
        bit     ready_m, v_exp, s1, s2;
        exp_t   e;
        ready_m = (ec - last_acc) >= (c_os - 1);
        check("o_ready", 32'(o_ready), 32'(ready_m));
        check("o_ready2", 32'(o_ready2), 32'(ready_m));
        ph = ec - last_acc;
        if (ph >= 0 && ph < c_os) begin
            acc = 0;
            for (int k = 0; k < c_l; k++) acc += longint'(m_coeff[k*c_os + ph] * m_x[k]);
            q.push_back('{due: ec + 2, acc: acc});
        end
        m_accepted = 1'b0;
        if (!i_reset) begin
            q.delete();
            for (int i = 0; i < c_n; i++) m_coeff[i] = 0;
            for (int k = 0; k < c_l; k++) m_x[k] = 0;
            last_acc = -100;
            last1 = 0;
            last2 = 0;
        end else begin
            if (i_coeff_we && i_coeff_addr < c_n) m_coeff[i_coeff_addr] = int'(i_coeff_data);
            if (i_valid && ready_m) begin
                for (int k = c_l - 1; k > 0; k--) m_x[k] = m_x[k-1];
                m_x[0] = int'(i_data);
                last_acc = ec + 1;
                m_accepted = 1'b1;
            end
        end
        @(posedge clk);
        ec++;
        #1;
        v_exp = (q.size() > 0) && (q[0].due == ec);
        s1 = 1'b0;
        s2 = 1'b0;
        check("o_valid", 32'(o_valid), 32'(v_exp));
        check("o_valid2", 32'(o_valid2), 32'(v_exp));
        if (v_exp) begin
            e = q.pop_front();
            e1 = scale(e.acc, 18, 17, s1);
            e2 = scale(e.acc, 10, 7, s2);
            last1 = e1;
            last2 = e2;
            obs_s.push_back(int'(o_sample));
            obs_sat.push_back(int'(o_sat));
            obs2_s.push_back(int'(o_sample2));
        end
        check("o_sample", 32'(o_sample), 32'(last1));
        check("o_sample2", 32'(o_sample2), 32'(last2));
        check("o_sat", 32'(o_sat), 32'(s1));
        check("o_sat2", 32'(o_sat2), 32'(s2));
    endtask

    task automatic write_coeff(input int addr, input int data);
        i_coeff_we   = 1'b1;
        i_coeff_addr = 5'(addr);
        i_coeff_data = 8'(data);
        tick();
        i_coeff_we   = 1'b0;
    endtask

    task automatic send(input int data);
        i_valid = 1'b1;
        i_data  = 8'(data);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (m_accepted) break;
        end
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        obs_s.delete();
        obs_sat.delete();
        obs2_s.delete();
    endtask

    initial begin
        checks = 0; errors = 0;
        i_reset = 1'b0; i_valid = 1'b0; i_data = '0;
        i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;
        for (int i = 0; i < c_n; i++) m_coeff[i] = 0;
        for (int k = 0; k < c_l; k++) m_x[k] = 0;
        last1 = 0; last2 = 0; m_accepted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ec = 0;
        last_acc = -100;
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_sample", 32'(o_sample), 32'(0));
        check("rst_sat", 32'(o_sat), 32'(0));
        check("rst_ready", 32'(o_ready), 32'(1));
        i_reset = 1'b1;

        // Impulse response: 24 outputs of (n+1)*512
        for (int i = 0; i < c_n; i++) write_coeff(i, i + 1);
        clear_obs();
        send(8'sh40);
        for (int i = 0; i < 5; i++) send(0);
        idle(8);
        check("imp_count", 32'(obs_s.size()), 32'(24));
        for (int n = 0; n < 24; n++) begin
            if (n < obs_s.size()) begin
                check("imp_out", 32'(obs_s[n]), 32'((n + 1) * 512));
                check("imp_sat", 32'(obs_sat[n]), 32'(0));
            end
        end

        // Full-scale negative input saturates to the minimum
        for (int i = 0; i < c_n; i++) write_coeff(i, 8'h7F);
        clear_obs();
        for (int i = 0; i < 7; i++) send(-128);
        idle(8);
        check("neg_count", 32'(obs_s.size()), 32'(28));
        for (int n = 24; n < 28; n++) begin
            if (n < obs_s.size()) begin
                check("neg_sat_val", 32'(obs_s[n]), 32'(-131072));
                check("neg_sat_flag", 32'(obs_sat[n]), 32'(1));
            end
        end

        // Single sample: ready low for three cycles then back to idle
        clear_obs();
        send(5);
        i_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("single_ready_low", 32'(o_ready), 32'(0));
            tick();
        end
        check("single_ready_last", 32'(o_ready), 32'(1));
        tick();
        check("single_ready_idle", 32'(o_ready), 32'(1));
        idle(6);
        check("single_count", 32'(obs_s.size()), 32'(4));

        // Half-LSB case on the narrow instance: 64 * 1 in Q14 is 0.5 LSB of Q7
        for (int i = 0; i < c_n; i++) write_coeff(i, (i == 0) ? 64 : 0);
        clear_obs();
        send(1);
        idle(8);
        check("round_count", 32'(obs2_s.size()), 32'(4));
        if (obs2_s.size() > 0) begin
`ifdef FIR_POLY_ROUND_EN
            check("round_phase0", 32'(obs2_s[0]), 32'(1));
`else
            check("round_phase0", 32'(obs2_s[0]), 32'(0));
`endif
            check("round_wide_phase0", 32'(obs_s[0]), 32'(512));
        end

        // Reset during phase 2 discards the burst and clears the coefficients
        for (int i = 0; i < c_n; i++) write_coeff(i, i + 1);
        send(20);
        i_valid = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        check("midrst_valid", 32'(o_valid), 32'(0));
        check("midrst_sample", 32'(o_sample), 32'(0));
        clear_obs();
        send(8'sh40);
        idle(8);
        check("midrst_count", 32'(obs_s.size()), 32'(4));
        for (int n = 0; n < 4; n++) begin
            if (n < obs_s.size()) check("midrst_zero", 32'(obs_s[n]), 32'(0));
        end

        // Coefficient write in phase 0 is seen by phase 1; x[1] still holds 0x40
        for (int i = 0; i < c_n; i++) write_coeff(i, i + 1);
        clear_obs();
        send(64);
        i_valid = 1'b0;
        write_coeff(1, 8'h10);
        idle(6);
        check("cwr_count", 32'(obs_s.size()), 32'(4));
        if (obs_s.size() > 1) begin
            check("cwr_phase0", 32'(obs_s[0]), 32'((1 * 64 + 5 * 64) * 8));
            check("cwr_phase1", 32'(obs_s[1]), 32'((16 * 64 + 6 * 64) * 8));
        end

        // Random traffic with random coefficient writes (some out of range)
        for (int i = 0; i < c_n; i++) write_coeff(i, int'($urandom_range(0, 255)));
        for (int n = 0; n < 400; n++) begin
            if (!i_valid || m_accepted) i_data = 8'($urandom);
            i_valid      = ($urandom_range(0, 9) < 7);
            i_coeff_we   = ($urandom_range(0, 9) == 0);
            i_coeff_addr = 5'($urandom_range(0, 31));
            i_coeff_data = 8'($urandom);
            tick();
        end
        i_coeff_we = 1'b0;
        idle(8);
        check("drain_empty", 32'(q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
